alu_flag_unit: RTL and testbench
================================

ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 SHALL have parameter SAVE_DEPTH, default 4, number of entries in the flag save stack (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports ex_valid/ex_wr_c/ex_wr_z/ex_uses_cin  input  1 each  EX-stage op valid, writes C, writes Z, consumes cin.
REQ-005 SHALL have ports ex_cout/ex_zero  input  1 each  ALU cout and Zero for the EX-stage op.
REQ-006 SHALL have port flush  input  1  kill the EX and MEM flag updates this cycle.
REQ-007 SHALL have ports br_valid  input  1 and br_cond  input  2  ID-stage branch request; 00=Z, 01=NZ, 10=C, 11=NC.
REQ-008 SHALL have ports push/pop  input  1 each  save/restore architectural flags (interrupt entry/return).
REQ-009 SHALL have outputs cin 1 (to ALU), br_taken 1, stall 1, c_flag 1, z_flag 1 (architectural), save_err 1 (sticky).

Function
REQ-010 SHALL hold two pending stages, MEM and WB, each {valid, wr_c, wr_z, c, z}; WB commits to c_flag/z_flag at the next edge, i.e. EX-to-architectural latency is exactly 3 edges.
REQ-011 SHALL load MEM from EX when ex_valid & ~flush & ~cin hazard, else load MEM invalid; MEM moves to WB unless flush, which invalidates it.
REQ-012 SHALL commit per-flag: C updates only when WB.valid & WB.wr_c; Z only when WB.valid & WB.wr_z.
REQ-013 SHALL drive cin combinationally from the newest C source: MEM (valid&wr_c), else WB (valid&wr_c), else c_flag.
REQ-014 SHALL evaluate br_taken combinationally from the newest flag among EX inputs (ex_valid&~flush), MEM, WB, architectural, per flag independently; br_taken=0 when br_valid=0.
REQ-015 SHALL implement a LIFO of SAVE_DEPTH {c,z} entries: push stores the flag values committed this cycle (post-WB next state); pop loads top into c_flag/z_flag and invalidates MEM and WB.
REQ-016 SHALL on pop in the same cycle as a WB commit let pop win; push and pop together are a no-op.
REQ-017 SHALL on push when full or pop when empty leave stack and flags unchanged and set save_err until reset.
REQ-018 SHALL assert stall only under REQ-024 conditions; with forwarding compiled in, stall is constant 0.

Reset
REQ-019 SHALL on rst_n=0 at an edge clear c_flag, z_flag, save_err, MEM.valid, WB.valid, stack pointer to 0, overriding all other inputs including push/pop.
REQ-020 SHALL drop in-flight updates on reset mid-operation; first commit after release arrives 3 edges after the first valid EX op.

Configuration
REQ-021 SHALL honour macro FLAG_FWD_EN.
REQ-022 SHALL, with FLAG_FWD_EN defined, forward per REQ-013/REQ-014.
REQ-023 SHALL, without FLAG_FWD_EN, drive cin=c_flag and evaluate branches on architectural flags only.
REQ-024 SHALL, without FLAG_FWD_EN, assert stall when (ex_valid&ex_uses_cin and MEM or WB pending C write) or (br_valid and any of EX/MEM/WB pending a write to the tested flag); a cin hazard inserts a MEM bubble.

Structure
REQ-025 SHALL place br_cond encodings, the pending-stage record typedef and the ALU operation codes (0000-1011) in shared package alu_pkg.
REQ-026 SHALL implement the save stack as sub-module flag_save_stack; everything else is in alu_flag_unit.

Verification
REQ-027 SHALL cover: reset, then ADD with cout=1, zero=0 at EX cycle 0 -> c_flag=1 after edge 3, z_flag unchanged 0.
REQ-028 SHALL cover: ADD cout=1 then ADC next cycle (uses_cin) -> cin=1 same cycle (FWD_EN); without macro stall=1 for 2 cycles, then cin=1.
REQ-029 SHALL cover: SUB zero=1 in EX with flush=1 -> z_flag stays 0; BZ in ID same cycle -> br_taken=0.
REQ-030 SHALL cover: SAVE_DEPTH=4, five pushes -> save_err=1 on fifth, stack holds first four; four pops restore in reverse order.
REQ-031 SHALL cover: pop coinciding with WB commit of C=1 over saved C=0 -> c_flag=0, MEM/WB invalidated.
REQ-032 SHALL cover: rst_n=0 while MEM and WB hold C=1 writes -> c_flag stays 0 after release, stall=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU flag unit: branch condition codes, ALU opcodes,
// the pending flag-stage record and the saved-flags entry.
package alu_pkg;

  typedef enum logic [1:0] {
    BR_Z  = 2'b00,
    BR_NZ = 2'b01,
    BR_C  = 2'b10,
    BR_NC = 2'b11
  } br_cond_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_ADC = 4'b0001,
    OP_SUB = 4'b0010,
    OP_SBC = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_NOT = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001,
    OP_CMP = 4'b1010,
    OP_MOV = 4'b1011
  } alu_op_e;

  typedef struct packed {
    logic valid;
    logic wrC;
    logic wrZ;
    logic c;
    logic z;
  } pend_t;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

endpackage

// File: rtl/flag_save_stack.sv
// LIFO of saved {c,z} flag pairs used on interrupt entry/return.
// Overflowing push or underflowing pop is ignored and latches a sticky error.
module flag_save_stack
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  logic   pop_i,
  input  flags_t wdata_i,
  output flags_t rdata_o,
  output logic   popOk_o,
  output logic   err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          err_q, err_d;
  flags_t        stack_q [DEPTH];
  logic          full, empty, pushOk, popOk;
  logic [AW-1:0] wrIdx, topIdx;

  always_comb begin
    full   = (ptr_q == PW'(DEPTH));
    empty  = (ptr_q == '0);
    pushOk = push_i & ~full;
    popOk  = pop_i & ~empty;
    wrIdx  = ptr_q[AW-1:0];
    topIdx = AW'(ptr_q - PW'(1));
    ptr_d  = ptr_q;
    if (pushOk) begin
      ptr_d = ptr_q + PW'(1);
    end else if (popOk) begin
      ptr_d = ptr_q - PW'(1);
    end
    err_d = err_q | (push_i & full) | (pop_i & empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  // Entry storage needs no reset; only the pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && pushOk) begin
      stack_q[wrIdx] <= wdata_i;
    end
  end

  assign rdata_o = stack_q[topIdx];
  assign popOk_o = popOk;
  assign err_o   = err_q;

endmodule

// File: rtl/alu_flag_unit.sv
// Carry/zero flag pipeline (MEM, WB pending stages) with save stack.
// Define FLAG_FWD_EN to forward pending flags instead of stalling.
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int SAVE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid,
  input  logic       ex_wr_c,
  input  logic       ex_wr_z,
  input  logic       ex_uses_cin,
  input  logic       ex_cout,
  input  logic       ex_zero,
  input  logic       flush,
  input  logic       br_valid,
  input  logic [1:0] br_cond,
  input  logic       push,
  input  logic       pop,
  output logic       cin,
  output logic       br_taken,
  output logic       stall,
  output logic       c_flag,
  output logic       z_flag,
  output logic       save_err
);

  pend_t  mem_q, mem_d, wb_q, wb_d;
  logic   cFlag_q, cFlag_d, zFlag_q, zFlag_d;
  logic   cCommit, zCommit;
  logic   memPendC, memPendZ, wbPendC, wbPendZ, exLive;
  logic   cinHaz, cNewest, zNewest, condHit;
  logic   stackPush, stackPop, popOk;
  flags_t stackTop, commitFlags;

  assign memPendC = mem_q.valid & mem_q.wrC;
  assign memPendZ = mem_q.valid & mem_q.wrZ;
  assign wbPendC  = wb_q.valid & wb_q.wrC;
  assign wbPendZ  = wb_q.valid & wb_q.wrZ;
  assign exLive   = ex_valid & ~flush;

  assign cCommit = wbPendC ? wb_q.c : cFlag_q;
  assign zCommit = wbPendZ ? wb_q.z : zFlag_q;

`ifdef FLAG_FWD_EN
  always_comb begin
    cin     = memPendC ? mem_q.c : (wbPendC ? wb_q.c : cFlag_q);
    cNewest = (exLive & ex_wr_c) ? ex_cout : cin;
    zNewest = (exLive & ex_wr_z) ? ex_zero :
              (memPendZ ? mem_q.z : (wbPendZ ? wb_q.z : zFlag_q));
    cinHaz  = 1'b0;
    stall   = 1'b0;
  end
`else
  // Without forwarding, any in-flight write to a consumed flag must drain first.
  always_comb begin
    cin     = cFlag_q;
    cNewest = cFlag_q;
    zNewest = zFlag_q;
    cinHaz  = ex_valid & ex_uses_cin & (memPendC | wbPendC);
    stall   = cinHaz;
    if (br_valid) begin
      if (br_cond[1]) begin
        stall = stall | (exLive & ex_wr_c) | memPendC | wbPendC;
      end else begin
        stall = stall | (exLive & ex_wr_z) | memPendZ | wbPendZ;
      end
    end
  end
`endif

  always_comb begin
    condHit = 1'b0;
    case (br_cond_e'(br_cond))
      BR_Z:    condHit = zNewest;
      BR_NZ:   condHit = ~zNewest;
      BR_C:    condHit = cNewest;
      BR_NC:   condHit = ~cNewest;
      default: condHit = 1'b0;
    endcase
    br_taken = br_valid & condHit;
  end

  assign stackPush   = push & ~pop;
  assign stackPop    = pop & ~push;
  assign commitFlags = '{c: cCommit, z: zCommit};

  // A successful pop overrides the WB commit and discards everything in flight.
  always_comb begin
    mem_d = '0;
    if (exLive & ~cinHaz) begin
      mem_d = '{valid: 1'b1, wrC: ex_wr_c, wrZ: ex_wr_z, c: ex_cout, z: ex_zero};
    end
    wb_d    = flush ? '0 : mem_q;
    cFlag_d = cCommit;
    zFlag_d = zCommit;
    if (popOk) begin
      mem_d   = '0;
      wb_d    = '0;
      cFlag_d = stackTop.c;
      zFlag_d = stackTop.z;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wb_q    <= '0;
      cFlag_q <= 1'b0;
      zFlag_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      cFlag_q <= cFlag_d;
      zFlag_q <= zFlag_d;
    end
  end

  flag_save_stack #(
    .DEPTH(SAVE_DEPTH)
  ) u_save_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (stackPush),
    .pop_i  (stackPop),
    .wdata_i(commitFlags),
    .rdata_o(stackTop),
    .popOk_o(popOk),
    .err_o  (save_err)
  );

  assign c_flag = cFlag_q;
  assign z_flag = zFlag_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios then random
// traffic, all checked against a queue-based model of in-flight flag writes.
module tb_alu_flag_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, ex_valid, ex_wr_c, ex_wr_z, ex_uses_cin, ex_cout, ex_zero;
  logic       flush, br_valid, push, pop;
  logic [1:0] br_cond;
  logic       cin, br_taken, stall, c_flag, z_flag, save_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit wrC;
    bit wrZ;
    bit c;
    bit z;
    int age;
  } flight_t;

  typedef struct {
    bit c;
    bit z;
  } save_t;

  flight_t inFlight[$];
  save_t   saved[$];
  bit      archC = 1'b0;
  bit      archZ = 1'b0;
  bit      errM  = 1'b0;
  bit      expCin, expBr, expStall;
  bit      obsStall;

  always #5 clk = ~clk;

  alu_flag_unit #(.SAVE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_wr_c(ex_wr_c),
    .ex_wr_z(ex_wr_z), .ex_uses_cin(ex_uses_cin), .ex_cout(ex_cout),
    .ex_zero(ex_zero), .flush(flush), .br_valid(br_valid), .br_cond(br_cond),
    .push(push), .pop(pop), .cin(cin), .br_taken(br_taken), .stall(stall),
    .c_flag(c_flag), .z_flag(z_flag), .save_err(save_err)
  );

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Expected combinational outputs: last in-flight writer of a flag wins.
  task automatic computeExpect();
    bit exLive, cF, zF, cN, zN, pendC, pendZ, hit;
    exLive = ex_valid && !flush;
    cF = archC; zF = archZ; pendC = 1'b0; pendZ = 1'b0;
    foreach (inFlight[i]) begin
      if (inFlight[i].wrC) begin cF = inFlight[i].c; pendC = 1'b1; end
      if (inFlight[i].wrZ) begin zF = inFlight[i].z; pendZ = 1'b1; end
    end
`ifdef FLAG_FWD_EN
    expCin   = cF;
    cN       = (exLive && ex_wr_c) ? ex_cout : cF;
    zN       = (exLive && ex_wr_z) ? ex_zero : zF;
    expStall = 1'b0;
`else
    expCin   = archC;
    cN       = archC;
    zN       = archZ;
    expStall = (ex_valid && ex_uses_cin && pendC) ||
               (br_valid && (br_cond[1] ? (pendC || (exLive && ex_wr_c))
                                        : (pendZ || (exLive && ex_wr_z))));
`endif
    case (br_cond)
      2'b00:   hit = zN;
      2'b01:   hit = !zN;
      2'b10:   hit = cN;
      default: hit = !cN;
    endcase
    expBr = br_valid && hit;
  endtask

  task automatic modelEdge();
    bit      nc, nz, pendC, accept;
    flight_t nextFlight[$];
    flight_t e;
    save_t   s;
    if (!rst_n) begin
      inFlight.delete(); saved.delete();
      archC = 1'b0; archZ = 1'b0; errM = 1'b0;
      return;
    end
    nc = archC; nz = archZ; pendC = 1'b0;
    foreach (inFlight[i]) begin
      pendC |= inFlight[i].wrC;
      if (inFlight[i].age == 2) begin
        if (inFlight[i].wrC) nc = inFlight[i].c;
        if (inFlight[i].wrZ) nz = inFlight[i].z;
      end else if (!flush) begin
        e = inFlight[i];
        e.age = 2;
        nextFlight.push_back(e);
      end
    end
`ifdef FLAG_FWD_EN
    accept = ex_valid && !flush;
`else
    accept = ex_valid && !flush && !(ex_uses_cin && pendC);
`endif
    if (accept) begin
      e.wrC = ex_wr_c; e.wrZ = ex_wr_z; e.c = ex_cout; e.z = ex_zero; e.age = 1;
      nextFlight.push_back(e);
    end
    if (push && !pop) begin
      if (saved.size() == DEPTH) errM = 1'b1;
      else begin s.c = nc; s.z = nz; saved.push_back(s); end
    end else if (pop && !push) begin
      if (saved.size() == 0) errM = 1'b1;
      else begin
        s = saved.pop_back();
        nc = s.c; nz = s.z;
        nextFlight.delete();
      end
    end
    inFlight = nextFlight;
    archC = nc;
    archZ = nz;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    computeExpect();
    obsStall = stall;
    checkOutput({tag, ".cin"}, cin, expCin);
    checkOutput({tag, ".br_taken"}, br_taken, expBr);
    checkOutput({tag, ".stall"}, stall, expStall);
    checkOutput({tag, ".c_flag"}, c_flag, archC);
    checkOutput({tag, ".z_flag"}, z_flag, archZ);
    checkOutput({tag, ".save_err"}, save_err, errM);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input string tag, input bit rs, input bit v,
                               input bit wc, input bit wz, input bit uc,
                               input bit co, input bit ze, input bit fl,
                               input bit bv, input bit [1:0] bc,
                               input bit pu, input bit po);
    rst_n = rs; ex_valid = v; ex_wr_c = wc; ex_wr_z = wz; ex_uses_cin = uc;
    ex_cout = co; ex_zero = ze; flush = fl; br_valid = bv; br_cond = bc;
    push = pu; pop = po;
    step(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1, 0,0,0,0,0,0,0, 0,2'b00, 0,0);
  endtask

  initial begin
    int stallCycles;
    bit [1:0] bits;

    applyStimulus("reset", 0, 1,1,1,0,1,1,0, 1,2'b10, 1,1);
    applyStimulus("reset", 0, 0,0,0,0,0,0,0, 0,2'b00, 0,0);
    checkOutput("reset_c", c_flag, 1'b0);
    checkOutput("reset_err", save_err, 1'b0);

    // ADD cout=1 zero=0 lands in the architectural flags after three edges.
    applyStimulus("add", 1, 1,1,1,0,1,0,0, 0,2'b00, 0,0);
    idle("add_drain", 2);
    checkOutput("add_c_after3", c_flag, 1'b1);
    checkOutput("add_z_after3", z_flag, 1'b0);

    // Clear C, then ADD cout=1 immediately followed by ADC consuming cin.
    applyStimulus("sub_c0", 1, 1,1,0,0,0,0,0, 0,2'b00, 0,0);
    idle("sub_drain", 3);
    applyStimulus("add2", 1, 1,1,0,0,1,0,0, 0,2'b00, 0,0);
    stallCycles = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus("adc", 1, 1,1,0,1,0,0,0, 0,2'b00, 0,0);
      if (obsStall === 1'b1) stallCycles++;
      else break;
    end
`ifdef FLAG_FWD_EN
    checkOutput("adc_no_stall", stallCycles == 0, 1'b1);
`else
    checkOutput("adc_stall2", stallCycles == 2, 1'b1);
`endif
    idle("adc_drain", 3);

    // Flushed SUB zero=1 with BZ in ID the same cycle.
    applyStimulus("sub_flush", 1, 1,0,1,0,0,1,1, 1,2'b00, 0,0);
    idle("flush_drain", 3);
    checkOutput("flush_z", z_flag, 1'b0);

    // Five pushes overflow a four-deep stack; four pops unwind it.
    for (int i = 0; i < 5; i++) begin
      bits = 2'(i);
      applyStimulus("push", 1, 1,1,1,0,bits[0],bits[1],0, 0,2'b00, 1,0);
      if (i == 3) checkOutput("push4_err", save_err, 1'b0);
    end
    checkOutput("push5_err", save_err, 1'b1);
    idle("push_drain", 3);
    for (int i = 0; i < 4; i++) applyStimulus("pop", 1, 0,0,0,0,0,0,0, 1,2'(i), 0,1);
    idle("pop_idle", 1);

    // Pop collides with WB commit of C=1 over a saved C=0.
    applyStimulus("reset2", 0, 0,0,0,0,0,0,0, 0,2'b00, 0,0);
    applyStimulus("save_c0", 1, 0,0,0,0,0,0,0, 0,2'b00, 1,0);
    applyStimulus("add_c1", 1, 1,1,0,0,1,0,0, 0,2'b00, 0,0);
    idle("add_mem", 1);
    applyStimulus("pop_wb", 1, 0,0,0,0,0,0,0, 0,2'b00, 0,1);
    checkOutput("pop_wins_c", c_flag, 1'b0);
    idle("pop_after", 3);

    // Reset while MEM and WB both hold C=1 writes.
    applyStimulus("inflight1", 1, 1,1,0,0,1,0,0, 0,2'b00, 0,0);
    applyStimulus("inflight2", 1, 1,1,0,0,1,0,0, 0,2'b00, 0,0);
    applyStimulus("reset_mid", 0, 0,0,0,0,0,0,0, 0,2'b00, 0,0);
    idle("reset_after", 3);
    checkOutput("reset_drop_c", c_flag, 1'b0);
    checkOutput("reset_drop_stall", stall, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus("rand", $urandom_range(49) != 0,
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), $urandom_range(7) == 0,
                    1'($urandom), 2'($urandom),
                    $urandom_range(7) == 0, $urandom_range(7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
